// File: rtl/opl3_host_bus_if.sv
// OPL3 host bus front end: turns four-port host writes (bank0/bank1 address
// and data) into paced single-cycle register-file write strobes. Data writes
// are queued in a FIFO so host bursts never stall, and are released no more
// often than once every MIN_WR_GAP clocks.

package opl3_host_bus_pkg;
   localparam int REG_FILE_DATA_WIDTH = 8;

   typedef struct packed {
      logic                           valid;
      logic                           bank;
      logic [7:0]                     addr;
      logic [REG_FILE_DATA_WIDTH-1:0] data;
   } opl3_reg_wr_t;
endpackage

module opl3_host_bus_if
   import opl3_host_bus_pkg::*;
#(
   parameter int FIFO_DEPTH = 16,
   parameter int MIN_WR_GAP = 4
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                host_wr,
   input  logic [1:0]                          host_addr,
   input  logic [REG_FILE_DATA_WIDTH-1:0]      host_din,
   output logic                                host_ready,
   output opl3_reg_wr_t                        opl3_reg_wr,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]     fifo_level,
   output logic                                fifo_overflow
);

   localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int GAP_W = (MIN_WR_GAP > 1) ? $clog2(MIN_WR_GAP) : 1;
   localparam int ENT_W = 1 + 8 + REG_FILE_DATA_WIDTH;

   localparam logic [LVL_W-1:0] FULL_LVL   = LVL_W'(FIFO_DEPTH);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(MIN_WR_GAP - 1);

   // Address latch: the last address written and the bank it was written to
   logic [7:0]       r_addr_latch;
   logic             r_bank_latch;

   // FIFO storage and bookkeeping; pointers wrap naturally since depth is 2^n
   logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [LVL_W-1:0] r_level;
   logic             r_overflow;

   // Pacing counter and registered output strobe
   logic [GAP_W-1:0] r_gap_cnt;
   opl3_reg_wr_t     r_reg_wr;

   logic             w_full;
   logic             w_empty;
   logic             w_data_wr;
   logic             w_addr_wr;
   logic             w_push;
   logic             w_drop;
   logic             w_pop;

   // Fullness is judged on the pre-edge occupancy, so a same-cycle pop never
   // makes room for a push that arrives while full.
   assign w_full    = (r_level == FULL_LVL);
   assign w_empty   = (r_level == '0);
   assign w_data_wr = host_wr &  host_addr[0];
   assign w_addr_wr = host_wr & ~host_addr[0];
   assign w_push    = w_data_wr & ~w_full;
   assign w_drop    = w_data_wr &  w_full;
   assign w_pop     = ~w_empty & (r_gap_cnt == '0);

   assign host_ready    = ~w_full;
   assign opl3_reg_wr   = r_reg_wr;
   assign fifo_level    = r_level;
   assign fifo_overflow = r_overflow;

   // Capture address-port writes; the bank follows the port that was used
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_latch <= '0;
         r_bank_latch <= 1'b0;
      end else if (w_addr_wr) begin
         r_addr_latch <= host_din;
         r_bank_latch <= host_addr[1];
      end
   end

   // Store accepted data writes tagged with the latch values from before this edge
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= {r_bank_latch, r_addr_latch, host_din};
      end
   end

   // Track pointers, occupancy and the sticky drop flag
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + 1'b1;
            2'b01:   r_level <= r_level - 1'b1;
            default: r_level <= r_level;
         endcase
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Release the FIFO head as a one-cycle strobe, then hold off for the gap
   always_ff @(posedge clk) begin
      if (reset) begin
         r_reg_wr  <= '0;
         r_gap_cnt <= '0;
      end else if (w_pop) begin
         r_reg_wr  <= {1'b1, r_mem[r_rd_ptr]};
         r_gap_cnt <= GAP_RELOAD;
      end else begin
         r_reg_wr.valid <= 1'b0;
         if (r_gap_cnt != '0) begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
         end
      end
   end

endmodule
